// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file constants and writeback entry type
package rf_pkg;

  localparam int XLEN     = 32;
  localparam int AW       = 5;
  localparam int NREGS    = 2 ** AW;
  localparam int WB_DEPTH = 4;

  typedef struct packed {
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - count-based writeback result buffer with async reset
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer wrap is plain overflow
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - register-file write-port arbiter with mul/div pending scoreboard
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int XLEN  = rf_pkg::XLEN,
  parameter int AW    = rf_pkg::AW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_we,
  input  logic [AW-1:0]   alu_wa,
  input  logic [XLEN-1:0] alu_wd,
  input  logic            md_valid,
  output logic            md_ready,
  input  logic [AW-1:0]   md_wa,
  input  logic [XLEN-1:0] md_wd,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [AW-1:0]   iss_wa,
  input  logic [AW-1:0]   chk_ra1,
  input  logic [AW-1:0]   chk_ra2,
  input  logic [AW-1:0]   chk_wa,
  output logic            stall,
  output logic            we3,
  output logic [AW-1:0]   wa3,
  output logic [XLEN-1:0] wd3
);

  localparam int NR = 2 ** AW;
  localparam int EW = AW + XLEN;

  logic [NR-1:0]   pending_q, pending_d;
  logic [EW-1:0]   head;
  logic [AW-1:0]   head_wa;
  logic [XLEN-1:0] head_wd;
  logic            fifo_full, fifo_empty;
  logic            alu_hit, drain, push, issue;

  assign head_wa = head[EW-1:XLEN];
  assign head_wd = head[XLEN-1:0];

  // Results bound for r0 complete the handshake but are never stored
  assign md_ready = ~fifo_full;
  assign push     = md_valid & md_ready & (md_wa != '0);

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (drain),
    .din   ({md_wa, md_wd}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ALU writeback cannot stall, so it always wins the port
  assign alu_hit = alu_we & (alu_wa != '0);
  assign drain   = ~alu_hit & ~fifo_empty;
  assign we3     = ~reset & (alu_hit | drain);

  always_comb begin
    wa3 = '0;
    wd3 = '0;
    if (alu_hit) begin
      wa3 = alu_wa;
      wd3 = alu_wd;
    end else if (drain) begin
      wa3 = head_wa;
      wd3 = head_wd;
    end
  end

  assign iss_ready = ~pending_q[iss_wa];
  assign issue     = iss_valid & iss_ready & (iss_wa != '0);
  assign stall     = pending_q[chk_ra1] | pending_q[chk_ra2] | pending_q[chk_wa];

  // iss_ready blocks a pending reg, so set and clear never target the same bit
  always_comb begin
    pending_d = pending_q;
    if (drain) pending_d[head_wa] = 1'b0;
    if (issue) pending_d[iss_wa]  = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_we, md_valid, iss_valid;
  logic [4:0]  alu_wa, md_wa, iss_wa, chk_ra1, chk_ra2, chk_wa;
  logic [31:0] alu_wd, md_wd;
  logic        md_ready, iss_ready, stall, we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;

  int vectors = 0;
  int miscompares = 0;

  rf_write_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_we(alu_we), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .md_valid(md_valid), .md_ready(md_ready), .md_wa(md_wa), .md_wd(md_wd),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_wa(iss_wa),
    .chk_ra1(chk_ra1), .chk_ra2(chk_ra2), .chk_wa(chk_wa),
    .stall(stall), .we3(we3), .wa3(wa3), .wd3(wd3)
  );

  always #5 clk = ~clk;

  // Reference: a queue of buffered results and one pending flag per register
  int unsigned q_wa[$];
  logic [31:0] q_wd[$];
  bit          pend[32];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q_wa.delete();
      q_wd.delete();
      for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    end else begin
      bit alu_wins, room, iss_ok;
      alu_wins = alu_we && alu_wa != 0;
      room     = q_wa.size() < 4;
      iss_ok   = iss_valid && !pend[iss_wa] && iss_wa != 0;
      if (!alu_wins && q_wa.size() > 0) begin
        pend[q_wa[0]] = 1'b0;
        void'(q_wa.pop_front());
        void'(q_wd.pop_front());
      end
      if (md_valid && room && md_wa != 0) begin
        q_wa.push_back(md_wa);
        q_wd.push_back(md_wd);
      end
      if (iss_ok) pend[iss_wa] = 1'b1;
    end
  end

  always @(negedge clk) begin
    bit          e_we, e_mr, e_ir, e_st;
    int unsigned e_wa;
    logic [31:0] e_wd;
    e_we = 0; e_wa = 0; e_wd = 0;
    if (alu_we && alu_wa != 0) begin
      e_we = 1; e_wa = alu_wa; e_wd = alu_wd;
    end else if (q_wa.size() > 0) begin
      e_we = 1; e_wa = q_wa[0]; e_wd = q_wd[0];
    end
    if (reset) e_we = 0;
    e_mr = q_wa.size() < 4;
    e_ir = !pend[iss_wa];
    e_st = pend[chk_ra1] | pend[chk_ra2] | pend[chk_wa];
    vectors++;
    if (we3 !== e_we) begin
      miscompares++;
      $display("FAIL we3 t=%0t got=%b exp=%b", $time, we3, e_we);
    end
    if (!reset && (wa3 !== 5'(e_wa) || wd3 !== e_wd)) begin
      miscompares++;
      $display("FAIL wport t=%0t got=%0d/%h exp=%0d/%h", $time, wa3, wd3, e_wa, e_wd);
    end
    if (md_ready !== e_mr) begin
      miscompares++;
      $display("FAIL md_ready t=%0t got=%b exp=%b", $time, md_ready, e_mr);
    end
    if (iss_ready !== e_ir) begin
      miscompares++;
      $display("FAIL iss_ready t=%0t got=%b exp=%b", $time, iss_ready, e_ir);
    end
    if (stall !== e_st) begin
      miscompares++;
      $display("FAIL stall t=%0t got=%b exp=%b", $time, stall, e_st);
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_we = 0; alu_wa = 0; alu_wd = 0;
    md_valid = 0; md_wa = 0; md_wd = 0;
    iss_valid = 0; iss_wa = 0;
    chk_ra1 = 0; chk_ra2 = 0; chk_wa = 0;
  endtask

  int outq[$];

  initial begin
    bit iss_acc, md_acc;
    reset = 1'b1;
    idle_inputs();
    repeat (2) next_cyc();
    lit("rst_we3", {31'b0, we3}, 32'd0);
    lit("rst_md_ready", {31'b0, md_ready}, 32'd1);
    lit("rst_iss_ready", {31'b0, iss_ready}, 32'd1);
    lit("rst_stall", {31'b0, stall}, 32'd0);
    reset = 1'b0;
    next_cyc();

    // single md result r9, pending cleared on its write edge
    iss_valid = 1; iss_wa = 9;
    next_cyc();
    iss_valid = 0; chk_ra1 = 9;
    #2 lit("t2_stall_set", {31'b0, stall}, 32'd1);
    md_valid = 1; md_wa = 9; md_wd = 32'h1234;
    next_cyc();
    md_valid = 0;
    #2;
    lit("t2_we3", {31'b0, we3}, 32'd1);
    lit("t2_wa3", {27'b0, wa3}, 32'd9);
    lit("t2_wd3", wd3, 32'h1234);
    lit("t2_stall_hold", {31'b0, stall}, 32'd1);
    next_cyc();
    #2 lit("t2_stall_clr", {31'b0, stall}, 32'd0);
    lit("t2_we3_idle", {31'b0, we3}, 32'd0);
    idle_inputs();
    next_cyc();

    // ALU owns the port for 5 cycles while two md results wait
    for (int c = 0; c < 5; c++) begin
      alu_we = 1; alu_wa = 3; alu_wd = 32'h300 + c;
      md_valid = (c < 2); md_wa = 5'(10 + c); md_wd = 32'hA0 + c;
      #2;
      lit("t3_alu_we3", {31'b0, we3}, 32'd1);
      lit("t3_alu_wa3", {27'b0, wa3}, 32'd3);
      next_cyc();
    end
    idle_inputs();
    #2 lit("t3_drain0", {27'b0, wa3}, 32'd10);
    lit("t3_drain0_wd", wd3, 32'hA0);
    next_cyc();
    #2 lit("t3_drain1", {27'b0, wa3}, 32'd11);
    next_cyc();
    #2 lit("t3_empty", {31'b0, we3}, 32'd0);
    next_cyc();

    // fill to DEPTH under ALU pressure, 5th result waits for a free slot
    alu_we = 1; alu_wa = 4; alu_wd = 32'h44;
    for (int c = 0; c < 4; c++) begin
      md_valid = 1; md_wa = 5'(12 + c); md_wd = 32'hC0 + c;
      next_cyc();
    end
    md_wa = 16; md_wd = 32'hD0;
    #2 lit("t4_full", {31'b0, md_ready}, 32'd0);
    next_cyc();
    #2 lit("t4_full_hold", {31'b0, md_ready}, 32'd0);
    next_cyc();
    alu_we = 0;
    #2 lit("t4_pop_ready", {31'b0, md_ready}, 32'd0);
    lit("t4_pop_wa3", {27'b0, wa3}, 32'd12);
    next_cyc();
    #2 lit("t4_reopen", {31'b0, md_ready}, 32'd1);
    next_cyc();
    md_valid = 0;
    repeat (6) next_cyc();
    idle_inputs();

    // pending r8 stalls decode until its result is written
    iss_valid = 1; iss_wa = 8;
    next_cyc();
    iss_valid = 0; chk_ra1 = 8;
    #2 lit("t5_stall", {31'b0, stall}, 32'd1);
    lit("t5_iss_ready", {31'b0, iss_ready}, 32'd0);
    md_valid = 1; md_wa = 8; md_wd = 32'h88;
    next_cyc();
    md_valid = 0;
    #2 lit("t5_write", {27'b0, wa3}, 32'd8);
    lit("t5_stall_wr", {31'b0, stall}, 32'd1);
    next_cyc();
    #2 lit("t5_unstall", {31'b0, stall}, 32'd0);
    idle_inputs();
    next_cyc();

    // r0 everywhere is a no-op
    alu_we = 1; md_valid = 1; iss_valid = 1;
    #2 lit("t6_we3", {31'b0, we3}, 32'd0);
    next_cyc();
    idle_inputs();
    #2 lit("t6_we3_next", {31'b0, we3}, 32'd0);
    lit("t6_stall", {31'b0, stall}, 32'd0);
    next_cyc();

    // reset mid-traffic: 3 buffered results, r5/r6/r7 pending
    for (int c = 0; c < 3; c++) begin
      alu_we = 1; alu_wa = 2; alu_wd = 32'h22;
      iss_valid = 1; iss_wa = 5'(5 + c);
      md_valid = 1; md_wa = 5'(20 + c); md_wd = 32'hE0 + c;
      next_cyc();
    end
    iss_valid = 0; md_valid = 0; chk_ra1 = 5; chk_ra2 = 6; chk_wa = 7; iss_wa = 5;
    #2 lit("t1_stall_pre", {31'b0, stall}, 32'd1);
    reset = 1;
    #1;
    lit("t1_we3", {31'b0, we3}, 32'd0);
    lit("t1_md_ready", {31'b0, md_ready}, 32'd1);
    lit("t1_stall", {31'b0, stall}, 32'd0);
    lit("t1_iss_ready", {31'b0, iss_ready}, 32'd1);
    next_cyc();
    reset = 0; alu_we = 0;
    #2 lit("t1_we3_after", {31'b0, we3}, 32'd0);
    idle_inputs();
    next_cyc();

    // mixed traffic, md results always return for issued destinations
    for (int c = 0; c < 300; c++) begin
      alu_we = ($urandom_range(0, 1) == 1); alu_wa = 5'($urandom); alu_wd = $urandom;
      iss_valid = ($urandom_range(0, 2) == 0); iss_wa = 5'($urandom);
      md_valid = (outq.size() > 0) && ($urandom_range(0, 1) == 1);
      md_wa = (outq.size() > 0) ? 5'(outq[0]) : 5'd0; md_wd = $urandom;
      chk_ra1 = 5'($urandom); chk_ra2 = 5'($urandom); chk_wa = 5'($urandom);
      #1;
      iss_acc = iss_valid && iss_ready && iss_wa != 0;
      md_acc = md_valid && md_ready;
      next_cyc();
      if (md_acc) void'(outq.pop_front());
      if (iss_acc) outq.push_back(int'(iss_wa));
    end
    idle_inputs();
    for (int c = 0; c < 40 && outq.size() > 0; c++) begin
      md_valid = 1; md_wa = 5'(outq[0]); md_wd = $urandom;
      #1 md_acc = md_ready;
      next_cyc();
      if (md_acc) void'(outq.pop_front());
    end
    idle_inputs();
    repeat (6) next_cyc();
    #2 lit("final_drained", {31'b0, we3}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
